// File: rtl/ft245_pkg.sv
// Shared definitions for the FT245 device model and its host-side bridge.
// The host timing constants here define the strobe widths both ends assume.
package ft245_pkg;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ACTIVE,
        R_RECOVER
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ACTIVE,
        W_RECOVER
    } wr_state_e;

    localparam int SYNC_STAGES = 2;

    // Host-side strobe timing, in system clock cycles.
    localparam int HOST_RD_PULSE_CYCLES = 8;
    localparam int HOST_RD_WAIT_CYCLES  = 5;
    localparam int HOST_WR_SETUP_CYCLES = 3;
    localparam int HOST_WR_PULSE_CYCLES = 7;

endpackage

// File: rtl/sync_fifo_axis.sv
// Single-clock FIFO with AXI-stream push and pop sides. Sink ready is a
// registered "not full" flag and is held low while in reset.
module sync_fifo_axis #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] s_tdata_i,
    input  logic             s_tvalid_i,
    output logic             s_tready_o,
    output logic [WIDTH-1:0] m_tdata_o,
    output logic             m_tvalid_o,
    input  logic             m_tready_i
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             ready_q;
    logic             full_d;
    logic             empty;
    logic             push;
    logic             pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign push  = s_tvalid_i && ready_q;
    assign pop   = m_tready_i && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        full_d = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                 (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ready_q  <= !full_d;
        end
    end

    // Storage is not reset; discarding contents is just a pointer reset.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= s_tdata_i;
    end

    assign s_tready_o = ready_q;
    assign m_tvalid_o = !empty;
    assign m_tdata_o  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/ft245_device_axis.sv
// Device (FIFO-chip) end of the asynchronous FT245 byte interface: answers
// host rd_n/wr_n strobes and bridges bytes to/from AXI-stream via two FIFOs.
module ft245_device_axis #(
    parameter int FIFO_DEPTH          = 16,
    parameter int RXF_INACTIVE_CYCLES = 2,
    parameter int TXE_INACTIVE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ft245_d_in,
    output logic [7:0] ft245_d_out,
    output logic       ft245_d_oe,
    input  logic       ft245_rd_n,
    input  logic       ft245_wr_n,
    output logic       ft245_rxf_n,
    output logic       ft245_txe_n,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       wr_overflow,
    output logic       rd_underflow
);

    import ft245_pkg::*;

    localparam int RCW = $clog2(RXF_INACTIVE_CYCLES + 2);
    localparam int WCW = $clog2(TXE_INACTIVE_CYCLES + 2);

    logic [SYNC_STAGES-1:0] rd_sync_q, wr_sync_q, sync_vld_q;
    logic                   rd_prev_q, wr_prev_q;
    logic                   rd_arm_q, wr_arm_q;
    logic                   rd_s, wr_s;
    logic                   rd_fall, rd_rise, wr_fall, wr_rise;

    logic [7:0] rx_head;
    logic       rx_valid;
    logic       rx_pop;
    logic       tx_ready;
    logic       tx_push;

    rd_state_e      rd_state_q, rd_state_d;
    logic [7:0]     d_out_q, d_out_d;
    logic           d_oe_q, d_oe_d;
    logic           rd_pres_q, rd_pres_d;
    logic           rxf_n_q, rxf_n_d;
    logic           rd_uf_q, rd_uf_d;
    logic [RCW-1:0] rd_cnt_q, rd_cnt_d;

    wr_state_e      wr_state_q, wr_state_d;
    logic           txe_n_q, txe_n_d;
    logic           wr_ov_q, wr_ov_d;
    logic [WCW-1:0] wr_cnt_q, wr_cnt_d;

    // sync_vld_q marks when the chain holds real pin samples rather than
    // reset values, so a strobe held low through reset never arms.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_sync_q  <= '1;
            wr_sync_q  <= '1;
            sync_vld_q <= '0;
            rd_prev_q  <= 1'b1;
            wr_prev_q  <= 1'b1;
            rd_arm_q   <= 1'b0;
            wr_arm_q   <= 1'b0;
        end else begin
            rd_sync_q  <= {rd_sync_q[SYNC_STAGES-2:0], ft245_rd_n};
            wr_sync_q  <= {wr_sync_q[SYNC_STAGES-2:0], ft245_wr_n};
            sync_vld_q <= {sync_vld_q[SYNC_STAGES-2:0], 1'b1};
            rd_prev_q  <= rd_s;
            wr_prev_q  <= wr_s;
            rd_arm_q   <= rd_arm_q | (sync_vld_q[SYNC_STAGES-1] & rd_s);
            wr_arm_q   <= wr_arm_q | (sync_vld_q[SYNC_STAGES-1] & wr_s);
        end
    end

    assign rd_s    = rd_sync_q[SYNC_STAGES-1];
    assign wr_s    = wr_sync_q[SYNC_STAGES-1];
    assign rd_fall = rd_arm_q &  rd_prev_q & ~rd_s;
    assign rd_rise = rd_arm_q & ~rd_prev_q &  rd_s;
    assign wr_fall = wr_arm_q &  wr_prev_q & ~wr_s;
    assign wr_rise = wr_arm_q & ~wr_prev_q &  wr_s;

    sync_fifo_axis #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk_i      (clk),
        .rst_i      (rst),
        .s_tdata_i  (s_axis_tdata),
        .s_tvalid_i (s_axis_tvalid),
        .s_tready_o (s_axis_tready),
        .m_tdata_o  (rx_head),
        .m_tvalid_o (rx_valid),
        .m_tready_i (rx_pop)
    );

    sync_fifo_axis #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk_i      (clk),
        .rst_i      (rst),
        .s_tdata_i  (ft245_d_in),
        .s_tvalid_i (tx_push),
        .s_tready_o (tx_ready),
        .m_tdata_o  (m_axis_tdata),
        .m_tvalid_o (m_axis_tvalid),
        .m_tready_i (m_axis_tready)
    );

    // Read FSM: the head is presented on the falling edge and only popped on
    // the rising edge, so an empty read never consumes anything.
    always_comb begin
        rd_state_d = rd_state_q;
        d_out_d    = d_out_q;
        d_oe_d     = d_oe_q;
        rd_pres_d  = rd_pres_q;
        rd_cnt_d   = rd_cnt_q;
        rd_uf_d    = 1'b0;
        rx_pop     = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                if (rd_fall) begin
                    rd_state_d = R_ACTIVE;
                    d_oe_d     = 1'b1;
                    if (rx_valid) begin
                        d_out_d   = rx_head;
                        rd_pres_d = 1'b1;
                    end else begin
                        rd_pres_d = 1'b0;
                        rd_uf_d   = 1'b1;
                    end
                end
            end
            R_ACTIVE: begin
                if (rd_rise) begin
                    rx_pop     = rd_pres_q;
                    rd_pres_d  = 1'b0;
                    d_oe_d     = 1'b0;
                    rd_cnt_d   = '0;
                    rd_state_d = R_RECOVER;
                end
            end
            R_RECOVER: begin
                if ((32'(rd_cnt_q) + 32'd1) >= 32'(RXF_INACTIVE_CYCLES))
                    rd_state_d = R_IDLE;
                else
                    rd_cnt_d = rd_cnt_q + RCW'(1);
            end
            default: rd_state_d = R_IDLE;
        endcase
        rxf_n_d = !((rd_state_d == R_IDLE) && rx_valid);
    end

    // Write FSM: the byte is taken straight off the bus on the falling edge;
    // tx_ready also guards the one cycle after reset where txe_n can lead it.
    always_comb begin
        wr_state_d = wr_state_q;
        wr_cnt_d   = wr_cnt_q;
        wr_ov_d    = 1'b0;
        tx_push    = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                if (wr_fall) begin
                    wr_state_d = W_ACTIVE;
                    if (!txe_n_q && tx_ready) tx_push = 1'b1;
                    else                      wr_ov_d = 1'b1;
                end
            end
            W_ACTIVE: begin
                if (wr_rise) begin
                    wr_cnt_d   = '0;
                    wr_state_d = W_RECOVER;
                end
            end
            W_RECOVER: begin
                if ((32'(wr_cnt_q) + 32'd1) >= 32'(TXE_INACTIVE_CYCLES))
                    wr_state_d = W_IDLE;
                else
                    wr_cnt_d = wr_cnt_q + WCW'(1);
            end
            default: wr_state_d = W_IDLE;
        endcase
        txe_n_d = !((wr_state_d == W_IDLE) && tx_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q <= R_IDLE;
            d_out_q    <= '0;
            d_oe_q     <= 1'b0;
            rd_pres_q  <= 1'b0;
            rxf_n_q    <= 1'b1;
            rd_uf_q    <= 1'b0;
            rd_cnt_q   <= '0;
            wr_state_q <= W_IDLE;
            txe_n_q    <= 1'b1;
            wr_ov_q    <= 1'b0;
            wr_cnt_q   <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            d_out_q    <= d_out_d;
            d_oe_q     <= d_oe_d;
            rd_pres_q  <= rd_pres_d;
            rxf_n_q    <= rxf_n_d;
            rd_uf_q    <= rd_uf_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_state_q <= wr_state_d;
            txe_n_q    <= txe_n_d;
            wr_ov_q    <= wr_ov_d;
            wr_cnt_q   <= wr_cnt_d;
        end
    end

    assign ft245_d_out  = d_out_q;
    assign ft245_d_oe   = d_oe_q;
    assign ft245_rxf_n  = rxf_n_q;
    assign ft245_txe_n  = txe_n_q;
    assign rd_underflow = rd_uf_q;
    assign wr_overflow  = wr_ov_q;

endmodule

// File: tb/tb_ft245_device_axis.sv
// Directed bench for ft245_device_axis: a table of host/AXI operations with
// hand-computed results, then multi-cycle sequences for the corner cases.
module tb_ft245_device_axis;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ft245_d_in;
    logic [7:0] ft245_d_out;
    logic       ft245_d_oe;
    logic       ft245_rd_n;
    logic       ft245_wr_n;
    logic       ft245_rxf_n;
    logic       ft245_txe_n;
    logic [7:0] s_axis_tdata;
    logic       s_axis_tvalid;
    logic       s_axis_tready;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready;
    logic       wr_overflow;
    logic       rd_underflow;

    always #5 clk = ~clk;

    ft245_device_axis #(
        .FIFO_DEPTH          (16),
        .RXF_INACTIVE_CYCLES (2),
        .TXE_INACTIVE_CYCLES (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ft245_d_in    (ft245_d_in),
        .ft245_d_out   (ft245_d_out),
        .ft245_d_oe    (ft245_d_oe),
        .ft245_rd_n    (ft245_rd_n),
        .ft245_wr_n    (ft245_wr_n),
        .ft245_rxf_n   (ft245_rxf_n),
        .ft245_txe_n   (ft245_txe_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .wr_overflow   (wr_overflow),
        .rd_underflow  (rd_underflow)
    );

    typedef enum {OP_SPUSH, OP_HRD, OP_HWR, OP_MPOP} op_e;
    typedef struct {
        op_e        op;
        logic [7:0] data;   // byte pushed/written, or byte expected on d_out / m_axis
        bit         flag;   // HRD: underflow expected
    } vec_t;

    int         pass_cnt  = 0;
    int         total_cnt = 0;
    int         ovf_cnt   = 0;
    int         uf_cnt    = 0;
    logic [7:0] mq[$];

    // Inputs change 1ns after posedge; outputs and pulses are observed on negedge.
    always @(negedge clk) begin
        if (wr_overflow)                    ovf_cnt++;
        if (rd_underflow)                   uf_cnt++;
        if (m_axis_tvalid && m_axis_tready) mq.push_back(m_axis_tdata);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    endtask

    task automatic s_push(input logic [7:0] d);
        int k;
        k = 0;
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        while (!s_axis_tready && k < 100) begin
            tick();
            k++;
        end
        chk("s_push ready timeout", 32'(k >= 100), 0);
        tick();
        s_axis_tvalid = 1'b0;
    endtask

    task automatic host_read(input logic [7:0] exp_d, input bit exp_uf, input string nm);
        int uf0;
        int k;
        uf0 = uf_cnt;
        if (!exp_uf) begin
            k = 0;
            while (ft245_rxf_n && k < 100) begin
                tick();
                k++;
            end
            chk({nm, " rxf_n low before read"}, 32'(ft245_rxf_n), 0);
        end else begin
            chk({nm, " rxf_n high on empty"}, 32'(ft245_rxf_n), 1);
        end
        ft245_rd_n = 1'b0;
        repeat (3) tick();
        chk({nm, " d_oe in pulse"}, 32'(ft245_d_oe), 1);
        chk({nm, " d_out"}, 32'(ft245_d_out), 32'(exp_d));
        chk({nm, " rxf_n in pulse"}, 32'(ft245_rxf_n), 1);
        repeat (5) tick();
        ft245_rd_n = 1'b1;
        repeat (3) tick();
        chk({nm, " d_oe after rise"}, 32'(ft245_d_oe), 0);
        chk({nm, " rxf_n after rise"}, 32'(ft245_rxf_n), 1);
        repeat (2) tick();
        chk({nm, " underflow pulses"}, 32'(uf_cnt - uf0), 32'(exp_uf));
    endtask

    task automatic host_write(input logic [7:0] d, input bit force_wr, input bit exp_ov,
                              input bit exp_lo, input string nm);
        int ov0;
        int k;
        ov0 = ovf_cnt;
        if (!force_wr) begin
            k = 0;
            while (ft245_txe_n && k < 100) begin
                tick();
                k++;
            end
            chk({nm, " txe_n low before write"}, 32'(ft245_txe_n), 0);
        end
        ft245_d_in = d;
        repeat (3) tick();
        ft245_wr_n = 1'b0;
        repeat (3) tick();
        chk({nm, " txe_n high in pulse"}, 32'(ft245_txe_n), 1);
        repeat (4) tick();
        ft245_wr_n = 1'b1;
        repeat (4) tick();
        chk({nm, " txe_n high in recovery"}, 32'(ft245_txe_n), 1);
        tick();
        if (exp_lo) chk({nm, " txe_n low after recovery"}, 32'(ft245_txe_n), 0);
        chk({nm, " overflow pulses"}, 32'(ovf_cnt - ov0), 32'(exp_ov));
    endtask

    task automatic m_pop(input logic [7:0] exp_d, input string nm);
        chk({nm, " m_tvalid"}, 32'(m_axis_tvalid), 1);
        chk({nm, " m_tdata"}, 32'(m_axis_tdata), 32'(exp_d));
        m_axis_tready = 1'b1;
        tick();
        m_axis_tready = 1'b0;
    endtask

    vec_t       tbl[16];
    logic [7:0] rx_data[24];
    logic [7:0] tx_data[24];

    initial begin
        int uf0;
        int ov0;
        int bad;

        tbl[0]  = '{OP_SPUSH, 8'hA5, 1'b0};
        tbl[1]  = '{OP_HRD,   8'hA5, 1'b0};
        tbl[2]  = '{OP_HRD,   8'hA5, 1'b1};  // empty read: d_out holds last byte
        tbl[3]  = '{OP_HWR,   8'h3C, 1'b0};
        tbl[4]  = '{OP_HWR,   8'h7E, 1'b0};
        tbl[5]  = '{OP_MPOP,  8'h3C, 1'b0};
        tbl[6]  = '{OP_MPOP,  8'h7E, 1'b0};
        tbl[7]  = '{OP_SPUSH, 8'h11, 1'b0};
        tbl[8]  = '{OP_SPUSH, 8'h22, 1'b0};
        tbl[9]  = '{OP_HRD,   8'h11, 1'b0};
        tbl[10] = '{OP_HRD,   8'h22, 1'b0};
        tbl[11] = '{OP_HRD,   8'h22, 1'b1};
        tbl[12] = '{OP_HWR,   8'h00, 1'b0};
        tbl[13] = '{OP_HWR,   8'hFF, 1'b0};
        tbl[14] = '{OP_MPOP,  8'h00, 1'b0};
        tbl[15] = '{OP_MPOP,  8'hFF, 1'b0};

        rst           = 1'b1;
        ft245_d_in    = 8'h00;
        ft245_rd_n    = 1'b1;
        ft245_wr_n    = 1'b1;
        s_axis_tdata  = 8'h00;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        repeat (3) tick();
        chk("reset d_out", 32'(ft245_d_out), 0);
        chk("reset d_oe", 32'(ft245_d_oe), 0);
        chk("reset rxf_n", 32'(ft245_rxf_n), 1);
        chk("reset txe_n", 32'(ft245_txe_n), 1);
        chk("reset s_tready", 32'(s_axis_tready), 0);
        chk("reset m_tvalid", 32'(m_axis_tvalid), 0);
        chk("reset pulses", 32'({wr_overflow, rd_underflow}), 0);
        rst = 1'b0;
        repeat (5) tick();
        chk("post-reset s_tready", 32'(s_axis_tready), 1);
        chk("post-reset txe_n", 32'(ft245_txe_n), 0);
        chk("post-reset rxf_n", 32'(ft245_rxf_n), 1);

        for (int i = 0; i < 16; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            case (tbl[i].op)
                OP_SPUSH: s_push(tbl[i].data);
                OP_HRD:   host_read(tbl[i].data, tbl[i].flag, nm);
                OP_HWR:   host_write(tbl[i].data, 1'b0, 1'b0, 1'b1, nm);
                OP_MPOP:  m_pop(tbl[i].data, nm);
                default:  ;
            endcase
        end

        // Back-to-back host writes streaming straight out of m_axis.
        mq.delete();
        m_axis_tready = 1'b1;
        host_write(8'h3C, 1'b0, 1'b0, 1'b1, "b2b wr0");
        host_write(8'h7E, 1'b0, 1'b0, 1'b1, "b2b wr1");
        repeat (3) tick();
        m_axis_tready = 1'b0;
        chk("b2b count", 32'(mq.size()), 2);
        chk("b2b byte0", 32'(mq[0]), 32'h3C);
        chk("b2b byte1", 32'(mq[1]), 32'h7E);

        // Fill the TX FIFO, force a 17th write, then drain.
        mq.delete();
        for (int i = 0; i < 16; i++)
            host_write(8'(8'h40 + i), 1'b0, 1'b0, (i < 15), $sformatf("fill%0d", i));
        repeat (3) tick();
        chk("full txe_n", 32'(ft245_txe_n), 1);
        host_write(8'hEE, 1'b1, 1'b1, 1'b0, "forced 17th");
        m_axis_tready = 1'b1;
        repeat (25) tick();
        m_axis_tready = 1'b0;
        chk("drain count", 32'(mq.size()), 16);
        bad = 0;
        for (int i = 0; i < 16; i++)
            if (mq.size() > i && mq[i] !== 8'(8'h40 + i)) bad++;
        chk("drain order", 32'(bad), 0);

        // Repeated reads on an empty RX FIFO.
        host_read(8'h22, 1'b1, "empty rd0");
        host_read(8'h22, 1'b1, "empty rd1");

        // Reset in the middle of a read, with rd_n held low across it.
        s_push(8'h5A);
        repeat (3) tick();
        ft245_rd_n = 1'b0;
        repeat (4) tick();
        chk("mid-rd d_oe", 32'(ft245_d_oe), 1);
        chk("mid-rd d_out", 32'(ft245_d_out), 32'h5A);
        rst = 1'b1;
        tick();
        chk("rst mid-rd d_oe", 32'(ft245_d_oe), 0);
        chk("rst mid-rd rxf_n", 32'(ft245_rxf_n), 1);
        chk("rst mid-rd d_out", 32'(ft245_d_out), 0);
        chk("rst mid-rd s_tready", 32'(s_axis_tready), 0);
        rst = 1'b0;
        uf0 = uf_cnt;
        repeat (12) tick();
        chk("held-low d_oe", 32'(ft245_d_oe), 0);
        chk("held-low rxf_n", 32'(ft245_rxf_n), 1);
        chk("held-low no underflow", 32'(uf_cnt - uf0), 0);
        ft245_rd_n = 1'b1;
        repeat (6) tick();
        s_push(8'h66);
        host_read(8'h66, 1'b0, "post-rst rd");

        // Concurrent traffic in both directions.
        for (int i = 0; i < 24; i++) begin
            rx_data[i] = 8'($urandom);
            tx_data[i] = 8'($urandom);
        end
        mq.delete();
        uf0 = uf_cnt;
        ov0 = ovf_cnt;
        m_axis_tready = 1'b1;
        fork
            begin
                for (int i = 0; i < 24; i++) s_push(rx_data[i]);
            end
            begin
                for (int i = 0; i < 24; i++) host_read(rx_data[i], 1'b0, $sformatf("cc rd%0d", i));
            end
            begin
                for (int i = 0; i < 24; i++) host_write(tx_data[i], 1'b0, 1'b0, 1'b0, $sformatf("cc wr%0d", i));
            end
        join
        repeat (4) tick();
        m_axis_tready = 1'b0;
        chk("cc tx count", 32'(mq.size()), 24);
        bad = 0;
        for (int i = 0; i < 24; i++)
            if (mq.size() > i && mq[i] !== tx_data[i]) bad++;
        chk("cc tx order", 32'(bad), 0);
        chk("cc no underflow", 32'(uf_cnt - uf0), 0);
        chk("cc no overflow", 32'(ovf_cnt - ov0), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
